// File: rtl/baked_connection_block_nclb.sv
// Connection block for one routing channel serving NCLB CLBs.
// The configuration is double-buffered: a serial shadow chain is loaded
// bit by bit, and set_in copies it into the active register that steers
// the routing. Shifting never touches the active register.
// Optional build macro: CB_OUTPUT_REG_EN registers clb_input, clb_cin and
// track_out on clk, adding one cycle of latency to the datapath.
module baked_connection_block_nclb #(
  parameter int WS     = 4,
  parameter int WD     = 8,
  parameter int NCLB   = 2,
  parameter int CLBIN  = 10,
  parameter int CLBOUT = 5,
  parameter int CARRY  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cen,
  input  logic                          set_in,
  input  logic                          shift_in,
  output logic                          shift_out,
  output logic                          cfg_loaded,
  input  logic [2*(WS+WD)-1:0]          track_in,
  output logic [2*(WS+WD)-1:0]          track_out,
  input  logic [NCLB*CLBOUT-1:0]        clb_output,
  input  logic [NCLB*CARRY-1:0]         clb_cout,
  input  logic [CARRY-1:0]              carry_in,
  output logic [NCLB*CLBIN-1:0]         clb_input,
  output logic [NCLB*CARRY-1:0]         clb_cin
);

  localparam int T     = 2*(WS+WD);
  localparam int SELW  = $clog2(T+1);
  localparam int OSELW = $clog2(NCLB*CLBOUT);
  localparam int CFG   = NCLB*CLBIN*SELW + T*(1+OSELW) + NCLB;
  localparam int CNTW  = $clog2(CFG+1);

  // Base offsets of the three active-register fields
  localparam int DRV_BASE   = NCLB*CLBIN*SELW;
  localparam int CARRY_BASE = CFG - NCLB;

  // Zero-extended mux sources sized to the full select range, so that any
  // out-of-range select naturally reads a constant 0.
  localparam int INX  = 1 << SELW;
  localparam int OUTX = 1 << OSELW;

  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(CFG);

  logic [CFG-1:0]  shadow;
  logic [CFG-1:0]  active;
  logic [CNTW-1:0] cnt;

  logic [INX-1:0]  track_ext;
  logic [OUTX-1:0] out_ext;

  logic [NCLB*CLBIN-1:0] clb_input_c;
  logic [NCLB*CARRY-1:0] clb_cin_c;
  logic [T-1:0]          track_out_c;

  // The top CLB's carry-out leaves through the tile above, not through here
  logic unused_top_cout;
  assign unused_top_cout = ^clb_cout[NCLB*CARRY-1 -: CARRY];

  // Shadow chain, active register and load-completeness tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      active     <= '0;
      cnt        <= '0;
      cfg_loaded <= 1'b0;
    end else if (cen) begin
      if (set_in) begin
        active     <= shadow;
        cnt        <= '0;
        cfg_loaded <= (cnt == CNT_FULL);
      end else begin
        shadow <= {shift_in, shadow[CFG-1:1]};
        if (cnt != CNT_FULL) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign shift_out = shadow[0];

  // Select 0 maps to the padding zero at bit 0, select s to track_in[s-1]
  assign track_ext = INX'({track_in, 1'b0});
  assign out_ext   = OUTX'(clb_output);

  genvar k, i, t;

  // CLB input multiplexers
  generate
    for (k = 0; k < NCLB; k++) begin : g_clb
      for (i = 0; i < CLBIN; i++) begin : g_in
        logic [SELW-1:0] in_sel;
        assign in_sel = active[(k*CLBIN+i)*SELW +: SELW];
        assign clb_input_c[k*CLBIN+i] = track_ext[in_sel];
      end
    end
  endgenerate

  // Outgoing track drivers: pass-through unless a CLB output is selected
  generate
    for (t = 0; t < T; t++) begin : g_trk
      logic             drv_en;
      logic [OSELW-1:0] drv_sel;
      assign drv_en  = active[DRV_BASE + t*(1+OSELW)];
      assign drv_sel = active[DRV_BASE + t*(1+OSELW) + 1 +: OSELW];
      assign track_out_c[t] = drv_en ? out_ext[drv_sel] : track_in[t];
    end
  endgenerate

  // Carry chain: each CLB takes the carry from the one below when enabled
  generate
    for (k = 0; k < NCLB; k++) begin : g_cry
      logic [CARRY-1:0] carry_src;
      if (k == 0) begin : g_first
        assign carry_src = carry_in;
      end else begin : g_rest
        assign carry_src = clb_cout[(k-1)*CARRY +: CARRY];
      end
      assign clb_cin_c[k*CARRY +: CARRY] =
        active[CARRY_BASE + k] ? carry_src : '0;
    end
  endgenerate

`ifdef CB_OUTPUT_REG_EN
  // Retime the datapath outputs; free-running, independent of cen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clb_input <= '0;
      clb_cin   <= '0;
      track_out <= '0;
    end else begin
      clb_input <= clb_input_c;
      clb_cin   <= clb_cin_c;
      track_out <= track_out_c;
    end
  end
`else
  assign clb_input = clb_input_c;
  assign clb_cin   = clb_cin_c;
  assign track_out = track_out_c;
`endif

endmodule

// File: tb/tb_baked_connection_block_nclb.sv
// Directed testbench for baked_connection_block_nclb with default
// parameters (T=24, SELW=5, OSELW=4, CFG=222). Every check is taken one
// clock after the stimulus change, so it holds with or without
// CB_OUTPUT_REG_EN.
module tb_baked_connection_block_nclb;

  localparam int CFG = 222;

  logic        clk;
  logic        rst;
  logic        cen;
  logic        set_in;
  logic        shift_in;
  logic        shift_out;
  logic        cfg_loaded;
  logic [23:0] track_in;
  logic [23:0] track_out;
  logic [9:0]  clb_output;
  logic [1:0]  clb_cout;
  logic [0:0]  carry_in;
  logic [19:0] clb_input;
  logic [1:0]  clb_cin;

  int vectors;
  int miscompares;

  logic [CFG-1:0] cfg;
  logic [15:0]    pattern;

  baked_connection_block_nclb dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .set_in     (set_in),
    .shift_in   (shift_in),
    .shift_out  (shift_out),
    .cfg_loaded (cfg_loaded),
    .track_in   (track_in),
    .track_out  (track_out),
    .clb_output (clb_output),
    .clb_cout   (clb_cout),
    .carry_in   (carry_in),
    .clb_input  (clb_input),
    .clb_cin    (clb_cin)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic shift_bit(input logic b);
    cen      = 1'b1;
    set_in   = 1'b0;
    shift_in = b;
    tick();
    cen      = 1'b0;
    shift_in = 1'b0;
  endtask

  task automatic pulse_set();
    cen    = 1'b1;
    set_in = 1'b1;
    tick();
    cen    = 1'b0;
    set_in = 1'b0;
  endtask

  // Bit 0 goes in first so it ends up at shadow[0]
  task automatic apply_stimulus(input logic [CFG-1:0] c);
    for (int n = 0; n < CFG; n++) begin
      shift_bit(c[n]);
    end
    pulse_set();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    cen         = 1'b0;
    set_in      = 1'b0;
    shift_in    = 1'b0;
    track_in    = 24'hA5A5A5;
    clb_output  = '0;
    clb_cout    = '0;
    carry_in    = 1'b1;

    // ---- reset state
    tick();
    tick();
    check_output("rst_clb_input", 32'(clb_input), 32'h0);
    check_output("rst_clb_cin", 32'(clb_cin), 32'h0);
`ifdef CB_OUTPUT_REG_EN
    check_output("rst_track_out", 32'(track_out), 32'h0);
`else
    check_output("rst_track_out", 32'(track_out), 32'hA5A5A5);
`endif
    check_output("rst_shift_out", 32'(shift_out), 32'h0);
    check_output("rst_cfg_loaded", 32'(cfg_loaded), 32'h0);
    rst = 1'b0;
    tick();
    check_output("post_rst_track_out", 32'(track_out), 32'hA5A5A5);

    // ---- CLB0 input0 select = 5 -> track_in[4]
    cfg = '0;
    cfg[4:0] = 5'd5;
    apply_stimulus(cfg);
    track_in = 24'h000010;
    tick();
    check_output("sel5_hit", 32'(clb_input), 32'h00001);
    check_output("sel5_loaded", 32'(cfg_loaded), 32'h1);
    check_output("sel5_cin_off", 32'(clb_cin), 32'h0);
    check_output("sel5_track_pass", 32'(track_out), 32'h000010);
    track_in = 24'h000008;
    tick();
    check_output("sel5_miss", 32'(clb_input), 32'h00000);

    // ---- select = 24 is the last legal track
    cfg[4:0] = 5'd24;
    apply_stimulus(cfg);
    track_in = 24'h800000;
    tick();
    check_output("sel24_hit", 32'(clb_input), 32'h00001);

    // ---- select = 25 is beyond T and reads 0
    cfg[4:0] = 5'd25;
    apply_stimulus(cfg);
    track_in = 24'hFFFFFF;
    tick();
    check_output("sel25_zero", 32'(clb_input), 32'h00000);
    check_output("sel25_track_pass", 32'(track_out), 32'hFFFFFF);

    // ---- track 3 driven from clb_output[7]: enable bit 115, select 119:116
    cfg = '0;
    cfg[115] = 1'b1;
    cfg[119:116] = 4'd7;
    apply_stimulus(cfg);
    track_in   = 24'hA5A5A5;
    clb_output = 10'h080;
    tick();
    check_output("drv7_one", 32'(track_out), 32'hA5A5AD);
    clb_output = 10'h37F;
    tick();
    check_output("drv7_zero", 32'(track_out), 32'hA5A5A5);

    // ---- select 12 is past the 10 CLB outputs
    cfg[119:116] = 4'd12;
    apply_stimulus(cfg);
    clb_output = 10'h3FF;
    tick();
    check_output("drv12_zero", 32'(track_out), 32'hA5A5A5);

    // ---- carry enables at bits 220 (CLB0) and 221 (CLB1)
    cfg = '0;
    cfg[220] = 1'b1;
    cfg[221] = 1'b1;
    apply_stimulus(cfg);
    clb_output = '0;
    carry_in   = 1'b1;
    clb_cout   = 2'b00;
    tick();
    check_output("carry_01", 32'(clb_cin), 32'h1);
    clb_cout = 2'b01;
    tick();
    check_output("carry_11", 32'(clb_cin), 32'h3);

    // CLB1 disabled; bit 100 (track 0 enable) seeds the next test
    cfg = '0;
    cfg[220] = 1'b1;
    cfg[100] = 1'b1;
    apply_stimulus(cfg);
    tick();
    check_output("carry_en1_off", 32'(clb_cin), 32'h1);

    // ---- partial load: 100 shifts, last two ones, then set
    // Old bit 100 lands at 0 (CLB0 in0 sel=1), old 220 at 120 (track 4
    // enable, sel 0), the two trailing ones become both carry enables.
    for (int n = 0; n < 100; n++) begin
      shift_bit(n >= 98);
    end
    pulse_set();
    track_in   = 24'hA5A5A5;
    clb_output = 10'h001;
    carry_in   = 1'b1;
    clb_cout   = 2'b01;
    tick();
    check_output("partial_loaded", 32'(cfg_loaded), 32'h0);
    check_output("partial_track", 32'(track_out), 32'hA5A5B5);
    check_output("partial_cin", 32'(clb_cin), 32'h3);
    check_output("partial_input", 32'(clb_input), 32'h00001);
    check_output("partial_shift_out", 32'(shift_out), 32'h1);

    // ---- set and shift together: set wins, shadow holds
    cen      = 1'b1;
    set_in   = 1'b1;
    shift_in = 1'b0;
    tick();
    tick();
    cen    = 1'b0;
    set_in = 1'b0;
    check_output("setshift_shift_out", 32'(shift_out), 32'h1);
    check_output("setshift_input", 32'(clb_input), 32'h00001);

    // One real shift moves shadow[1]=0 into place
    shift_bit(1'b1);
    check_output("single_shift", 32'(shift_out), 32'h0);

    // ---- cen low: set_in and shift_in ignored
    for (int n = 0; n < 4; n++) begin
      cen      = 1'b0;
      set_in   = n[0];
      shift_in = ~n[0];
      tick();
    end
    set_in   = 1'b0;
    shift_in = 1'b0;
    tick();
    check_output("cen0_shift_out", 32'(shift_out), 32'h0);
    check_output("cen0_input", 32'(clb_input), 32'h00001);
    check_output("cen0_track", 32'(track_out), 32'hA5A5B5);

    // ---- chain passthrough: first bit appears after 222 shifts
    pattern = 16'hB38D;
    for (int n = 0; n < 16; n++) begin
      shift_bit(pattern[n]);
    end
    for (int n = 16; n < CFG; n++) begin
      shift_bit(1'b0);
    end
    check_output("chain_bit0", 32'(shift_out), 32'(pattern[0]));
    for (int n = 1; n < 16; n++) begin
      shift_bit(1'b0);
      check_output($sformatf("chain_bit%0d", n), 32'(shift_out),
                   32'(pattern[n]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
